// File: rtl/pattern_scan_pkg.sv
// Shared types and defaults for the switch-pattern recognizer.
// Holds the controller state encoding, default width and default target.
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    FILL,
    ARMED,
    HOLD
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [7:0] TARGET_DEFAULT = 8'b0000_0100;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for a raw pushbutton.
// Ports: clk, reset (async high), din (raw), sync (synced level), fall (press strobe).
module key_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  // s3 is the previous synced level: a held key strobes once.
  assign fall = s3 & ~s2;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: shifts one bit per key press, flags a window==target hit.
// Ports: clk, reset, key_n, bit_in, target -> window, fill_cnt, armed, match, match_pulse,
// match_count (only when PATTERN_SCAN_COUNT_EN is defined).
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_n,
  input  logic                       bit_in,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           window,
  output logic [$clog2(WIDTH+1)-1:0] fill_cnt,
  output logic                       armed,
  output logic                       match,
  output logic                       match_pulse
`ifdef PATTERN_SCAN_COUNT_EN
  ,
  output logic [7:0]                 match_count
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FULL = FW'(WIDTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [WIDTH-1:0] shift_win, window_n;
  logic [FW-1:0] shift_fill, fill_n;
  logic strobe, key_s, hit;
  logic b1, b2;

  key_sync_edge #(
    .RST_VAL(1'b1)
  ) u_key (
    .clk  (clk),
    .reset(reset),
    .din  (key_n),
    .sync (key_s),
    .fall (strobe)
  );

  // Data bit only needs the level synchronizer, no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b1 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      b1 <= bit_in;
      b2 <= b1;
    end
  end

  always_comb begin
    shift_win  = {window[WIDTH-2:0], b2};
    shift_fill = (fill_cnt == FULL) ? FULL : fill_cnt + FW'(1);
    // Compare only on a press so a target change alone never hits.
    hit      = strobe && (shift_fill == FULL) && (shift_win == target);
    window_n = strobe ? shift_win : window;
    fill_n   = strobe ? shift_fill : fill_cnt;
    state_n  = state;
    hold_n   = hold_cnt;
    unique case (state)
      FILL: begin
        if (strobe && shift_fill == FULL)
          state_n = hit ? HOLD : ARMED;
      end
      ARMED: begin
        if (hit)
          state_n = HOLD;
      end
      HOLD: begin
        if (!hit) begin
          if (hold_cnt == '0)
            state_n = ARMED;
          else
            hold_n = hold_cnt - HW'(1);
        end
      end
      default: state_n = FILL;
    endcase
    if (hit)
      hold_n = HOLD_LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      hold_cnt    <= '0;
      window      <= '0;
      fill_cnt    <= '0;
      armed       <= 1'b0;
      match       <= 1'b0;
      match_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      hold_cnt    <= hold_n;
      window      <= window_n;
      fill_cnt    <= fill_n;
      armed       <= (fill_n == FULL);
      match       <= (state_n == HOLD);
      match_pulse <= hit;
    end
  end

`ifdef PATTERN_SCAN_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      match_count <= '0;
    else if (hit && match_count != 8'hff)
      match_count <= match_count + 8'd1;
  end
`endif

  logic unused_ok;
  assign unused_ok = key_s;

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencing controller for the switch-pattern recognizer: accepts one serial bit per pushbutton press, assembles the last WIDTH bits into a sliding window, and compares the window against a target pattern after every press. On a match it raises a one-cycle pulse and holds a visible match flag for a programmable time. It sits between the DE1_SoC board inputs (KEY, SW) and the LEDR/HEX outputs in the top level.

## Interface
- WIDTH, 8: window and target width in bits; ≥2.
- HOLD_CYCLES, 25_000_000: cycles `match` stays high after a match (0.5 s at 50 MHz); ≥1.
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-high reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- bit_in  in  1  raw serial data bit (switch), asynchronous to clk.
- target  in  WIDTH  pattern to recognize; window[WIDTH-1] is the oldest bit.
- window  out  WIDTH  current shift window.
- fill_cnt  out  $clog2(WIDTH+1)  number of valid bits, saturates at WIDTH.
- armed  out  1  high when fill_cnt == WIDTH.
- match  out  1  high while in HOLD.
- match_pulse  out  1  one-cycle strobe per detected match.
- match_count  out  8  saturating match counter (only with PATTERN_SCAN_COUNT_EN).

## Operation
- key_n and bit_in each pass through a 2-flop synchronizer. key_n flops reset to 1; bit_in flops reset to 0.
- Press strobe = previous synchronized key high and current synchronized key low. A held key produces exactly one strobe. Release produces none.
- On strobe: window <= {window[WIDTH-2:0], bit_sync}; fill_cnt <= min(fill_cnt+1, WIDTH).
- Compare happens only on a strobe, using the post-shift window and post-increment fill_cnt. Hit = (new fill_cnt == WIDTH) && (new window == target).
- A change to `target` between strobes never causes a match.
- FSM states:
  - FILL: fill_cnt < WIDTH. The WIDTH-th strobe goes to HOLD on a hit, otherwise to ARMED.
  - ARMED: on a strobe with a hit, go to HOLD.
  - HOLD: hold_cnt decrements every cycle. A strobe with a hit reloads hold_cnt and pulses match_pulse again (retrigger). When hold_cnt == 0 and there is no hit, go to ARMED.
- Entering or retriggering HOLD loads hold_cnt = HOLD_CYCLES-1.
- Shifting continues in every state.

## Timing
- Reset values: window=0, fill_cnt=0, armed=0, match=0, match_pulse=0, match_count=0, state=FILL, hold_cnt=0.
- Reset asserted mid-HOLD clears `match` immediately (asynchronous).
- Latency: raw key_n fall captured at edge N → window, fill_cnt, armed, match, match_pulse update at edge N+2.
- bit_in must be stable from 3 cycles before until 3 cycles after the key_n fall.
- `match` stays high exactly HOLD_CYCLES cycles after the last hit (extended by retrigger).
- match_pulse is high for exactly one cycle per hit, including retriggers.
- hold_cnt width: $clog2(HOLD_CYCLES) bits, minimum 1.
- All outputs are registered.

## Configuration
- PATTERN_SCAN_COUNT_EN defined: `match_count` port present. It increments on every match_pulse and saturates at 255. Only reset clears it.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package pattern_scan_pkg:
  - state typedef enum logic [1:0] {FILL, ARMED, HOLD}.
  - WIDTH_DEFAULT = 8.
  - Default target constant 8'b0000_0100.
- Sub-module key_sync_edge holds the 2-flop synchronizer and falling-edge detector. pattern_scan_ctrl instantiates it for key_n; bit_in uses its synchronizer path only.

## Test plan
All scenarios use WIDTH=8, HOLD_CYCLES=4.
- Fill and match: target=8'h04; press bits 0,0,0,0,0,1,0,0 → after 8th press window=8'h04, armed=1, match_pulse one cycle, match high 4 cycles, then state ARMED.
- Partial fill: 7 presses of a suffix of the target → fill_cnt=7, armed=0, no match_pulse.
- Sliding/retrigger: after the match, press 0×8 with target=8'h00 mid-HOLD → match_pulse on each hit; match stays high until 4 cycles after the last hit.
- Held key: key_n low for 100 cycles, bit_in=1 → exactly one shift, fill_cnt +1; release → no shift.
- Async reset mid-HOLD: assert reset two cycles into HOLD → match=0 within the same cycle; all outputs zero; first press after release gives fill_cnt=1.
- Count (macro on): 300 matches → match_count=255 and holds; without macro, elaboration succeeds with no match_count port.
